// File: rtl/wb_bus_arbiter_if.sv
// Wishbone B4 bus bundle (classic + registered-feedback burst signals).
// The master modport is the side that issues requests; the slave modport answers them.
interface wb_bus_arbiter_if;
  logic [29:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, cyc, stb, we, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, cyc, stb, we, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter: ibus (master 0) and dbus (master 1) share one mem port.
// Round-robin on simultaneous requests, grant held for the whole bus cycle, and a
// watchdog that answers a stalled strobe with err followed by a one-cycle abort.
module wb_bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  wb_bus_arbiter_if.slave         ibus,
  wb_bus_arbiter_if.slave         dbus,
  wb_bus_arbiter_if.master        mem,
  output logic [1:0]              grant,
  output logic                    timeout_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam int               TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST   = TO_LAST_I[CNT_W-1:0];

  state_t           state;
  logic             last_d;
  logic [CNT_W-1:0] wd_cnt;

  logic sel_d;
  logic owner_active;
  logic owner_cyc;
  logic owner_stb;
  logic bus_cyc;
  logic bus_stb;
  logic fire;
  logic fwd_ack;
  logic fwd_err;

  // Route the owner's request to the slave and steer the response back to the owner only.
  always_comb begin
    sel_d        = grant[1];
    owner_active = (state == GNT_I) || (state == GNT_D);
    owner_cyc    = sel_d ? dbus.cyc : ibus.cyc;
    owner_stb    = sel_d ? dbus.stb : ibus.stb;
    // ABORT keeps the grant but forces the bus idle for one cycle.
    bus_cyc      = owner_active && owner_cyc;
    bus_stb      = bus_cyc && owner_stb;
    fire         = (TIMEOUT != 0) && bus_stb && (wd_cnt == TO_LAST);
    // err wins over a simultaneous ack; a watchdog hit swallows any late ack.
    fwd_err      = bus_cyc && (mem.err || fire);
    fwd_ack      = bus_cyc && mem.ack && !mem.err && !fire;

    mem.adr      = sel_d ? dbus.adr   : ibus.adr;
    mem.dat_w    = sel_d ? dbus.dat_w : ibus.dat_w;
    mem.sel      = sel_d ? dbus.sel   : ibus.sel;
    mem.we       = sel_d ? dbus.we    : ibus.we;
    mem.cti      = sel_d ? dbus.cti   : ibus.cti;
    mem.bte      = sel_d ? dbus.bte   : ibus.bte;
    mem.cyc      = bus_cyc;
    mem.stb      = bus_stb;

    ibus.dat_r   = mem.dat_r;
    dbus.dat_r   = mem.dat_r;
    ibus.ack     = (state == GNT_I) && fwd_ack;
    ibus.err     = (state == GNT_I) && fwd_err;
    dbus.ack     = (state == GNT_D) && fwd_ack;
    dbus.err     = (state == GNT_D) && fwd_err;

    timeout_pulse = fire;
  end

  // Ownership FSM: grant on request, hold while the owner keeps cyc, hand off without a bubble.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      last_d <= 1'b0;
      grant  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (dbus.cyc && (!ibus.cyc || !last_d)) begin
            state  <= GNT_D;
            grant  <= 2'b10;
            last_d <= 1'b1;
          end else if (ibus.cyc) begin
            state  <= GNT_I;
            grant  <= 2'b01;
            last_d <= 1'b0;
          end
        end
        GNT_I: begin
          if (fire) begin
            state <= ABORT;
          end else if (!ibus.cyc) begin
            if (dbus.cyc) begin
              state  <= GNT_D;
              grant  <= 2'b10;
              last_d <= 1'b1;
            end else begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end
        end
        GNT_D: begin
          if (fire) begin
            state <= ABORT;
          end else if (!dbus.cyc) begin
            if (ibus.cyc) begin
              state  <= GNT_I;
              grant  <= 2'b01;
              last_d <= 1'b0;
            end else begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end
        end
        default: begin
          // last_d already names the aborted owner, so it loses the next tie.
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Watchdog: count consecutive unanswered strobe cycles, saturating, cleared on any response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if ((TIMEOUT == 0) || !bus_stb || mem.ack || mem.err || fire) begin
      wd_cnt <= '0;
    end else if (wd_cnt != '1) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule
